// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to an incoming Fibonacci LFSR stream, then counts bit errors.
// Define PRBS_CHK_BITCNT_EN to add the bit_count output (valid bits compared while locked).
module prbs_checker #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] TAPS        = WIDTH'(8'hB8),
   parameter int unsigned      LOCK_COUNT  = 16,
   parameter int unsigned      WINDOW      = 64,
   parameter int unsigned      LOSS_THRESH = 8,
   parameter int unsigned      CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic             sync_loss,
   output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
   ,
   output logic [CNT_W-1:0] bit_count
`endif
);

   localparam int unsigned FILL_W = $clog2(WIDTH + 1);
   localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int unsigned WCNT_W = $clog2(WINDOW + 1);
   localparam int unsigned WERR_W = $clog2(LOSS_THRESH + 1);

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   s, s_nxt;
   logic [FILL_W-1:0]  fill, fill_nxt;
   logic [RUN_W-1:0]   run, run_nxt;
   logic [WCNT_W-1:0]  win_cnt, win_cnt_nxt;
   logic [WERR_W-1:0]  win_err, win_err_nxt;
   logic               err_pulse_nxt, sync_loss_nxt;
   logic [CNT_W-1:0]   err_count_nxt;
   logic               e, mism;
`ifdef PRBS_CHK_BITCNT_EN
   logic [CNT_W-1:0]   bit_count_nxt;
`endif

   // Next-state and next-output logic; only valid bits advance anything.
   always_comb begin
      state_nxt     = state;
      s_nxt         = s;
      fill_nxt      = fill;
      run_nxt       = run;
      win_cnt_nxt   = win_cnt;
      win_err_nxt   = win_err;
      err_pulse_nxt = 1'b0;
      sync_loss_nxt = 1'b0;
      err_count_nxt = err_count;
`ifdef PRBS_CHK_BITCNT_EN
      bit_count_nxt = bit_count;
`endif
      e    = ^(s & TAPS);
      mism = bit_in ^ e;

      if (bit_valid) begin
         case (state)
            SEARCH: begin
               s_nxt    = {s[WIDTH-2:0], bit_in};
               fill_nxt = fill + FILL_W'(1);
               if (fill_nxt == FILL_W'(WIDTH)) begin
                  state_nxt = VERIFY;
                  run_nxt   = '0;
               end
            end
            VERIFY: begin
               // An all-zero register predicts zeros forever, so it must never count toward lock.
               if (s == '0) begin
                  s_nxt   = {s[WIDTH-2:0], bit_in};
                  run_nxt = '0;
               end else if (!mism) begin
                  s_nxt   = {s[WIDTH-2:0], e};
                  run_nxt = run + RUN_W'(1);
                  if (run_nxt == RUN_W'(LOCK_COUNT)) begin
                     state_nxt   = LOCKED;
                     win_cnt_nxt = '0;
                     win_err_nxt = '0;
                  end
               end else begin
                  s_nxt   = {s[WIDTH-2:0], bit_in};
                  run_nxt = '0;
               end
            end
            LOCKED: begin
               s_nxt       = {s[WIDTH-2:0], e};
               win_cnt_nxt = win_cnt + WCNT_W'(1);
`ifdef PRBS_CHK_BITCNT_EN
               if (bit_count != '1) bit_count_nxt = bit_count + CNT_W'(1);
`endif
               if (mism) begin
                  err_pulse_nxt = 1'b1;
                  win_err_nxt   = win_err + WERR_W'(1);
                  if (err_count != '1) err_count_nxt = err_count + CNT_W'(1);
               end
               // Loss of sync wins over the window wrap on the same bit.
               if (win_err_nxt == WERR_W'(LOSS_THRESH)) begin
                  state_nxt     = SEARCH;
                  fill_nxt      = '0;
                  sync_loss_nxt = 1'b1;
               end else if (win_cnt_nxt == WCNT_W'(WINDOW)) begin
                  win_cnt_nxt = '0;
                  win_err_nxt = '0;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end

      if (clear_cnt) begin
         err_count_nxt = '0;
`ifdef PRBS_CHK_BITCNT_EN
         bit_count_nxt = '0;
`endif
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEARCH;
         s         <= '0;
         fill      <= '0;
         run       <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         sync_loss <= 1'b0;
         err_count <= '0;
`ifdef PRBS_CHK_BITCNT_EN
         bit_count <= '0;
`endif
      end else begin
         state     <= state_nxt;
         s         <= s_nxt;
         fill      <= fill_nxt;
         run       <= run_nxt;
         win_cnt   <= win_cnt_nxt;
         win_err   <= win_err_nxt;
         locked    <= (state_nxt == LOCKED);
         err_pulse <= err_pulse_nxt;
         sync_loss <= sync_loss_nxt;
         err_count <= err_count_nxt;
`ifdef PRBS_CHK_BITCNT_EN
         bit_count <= bit_count_nxt;
`endif
      end
   end

endmodule
